// File: rtl/jtag_tap_dmi.sv
// JTAG TAP with a RISC-V style debug transport (IDCODE, DTMCS, DMI, BYPASS).
// TCK/TMS/TDI are oversampled on clk_i; every TAP action happens on a
// detected TCK edge, so the block runs in a single clock domain.
module jtag_tap_dmi #(
   parameter logic [31:0] IdcodeValue = 32'h1000_0001,
   parameter int unsigned AbitsW      = 7
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              jtag_tck,
   input  logic              jtag_tms,
   input  logic              jtag_tdi,
   input  logic              jtag_trst_n,
   output logic              jtag_tdo,
   output logic              dmi_req_valid,
   input  logic              dmi_req_ready,
   output logic [AbitsW-1:0] dmi_req_addr,
   output logic [31:0]       dmi_req_data,
   output logic [1:0]        dmi_req_op,
   input  logic              dmi_rsp_valid,
   input  logic [31:0]       dmi_rsp_data,
   input  logic [1:0]        dmi_rsp_resp
);

   localparam int unsigned DrW = AbitsW + 34;

   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_e;

   typedef enum logic [1:0] {SEL_BYP, SEL_IDC, SEL_DTM, SEL_DMI} dr_sel_e;

   // pin sampling and edge detection
   logic r_tck, r_tck_d, r_tms, r_tdi;
   logic w_rise, w_fall, w_adv;

   // TAP FSM
   tap_e r_state, w_next;
   logic w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir, w_in_tlr;

   // IR / DR
   logic [4:0]     r_ir, r_ir_sr;
   logic [DrW-1:0] r_dr, w_dr_shr, w_dr_shift, w_dr_cap;
   dr_sel_e        w_dr_sel;
   int             w_dr_len;
   logic [31:0]    w_dtmcs;
   logic           r_tdo;

   // DMI tracking
   logic              r_req_valid, r_outstanding;
   logic [AbitsW-1:0] r_req_addr;
   logic [31:0]       r_req_data, r_rsp_data, w_cap_data;
   logic [1:0]        r_req_op, r_sticky, w_cap_stat, w_op;
   logic              w_rsp_fire, w_busy, w_issue;
   logic              w_upd_dmi, w_upd_dtm, w_cap_dmi;

   assign w_rise = r_tck & ~r_tck_d;
   assign w_fall = ~r_tck & r_tck_d;
   // TAP reset suppresses all TAP actions on the same edge
   assign w_adv  = w_rise & jtag_trst_n;

   // register the JTAG pins once and keep a delayed TCK for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tck   <= 1'b0;
         r_tck_d <= 1'b0;
         r_tms   <= 1'b0;
         r_tdi   <= 1'b0;
      end else begin
         r_tck   <= jtag_tck;
         r_tck_d <= r_tck;
         r_tms   <= jtag_tms;
         r_tdi   <= jtag_tdi;
      end
   end

   // TAP state register: advances only on TCK rising edges
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           r_state <= TLR;
      else if (!jtag_trst_n) r_state <= TLR;
      else if (w_rise)       r_state <= w_next;
   end

   // IEEE 1149.1 next-state function
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         TLR:    w_next = r_tms ? TLR    : RTI;
         RTI:    w_next = r_tms ? SEL_DR : RTI;
         SEL_DR: w_next = r_tms ? SEL_IR : CAP_DR;
         CAP_DR: w_next = r_tms ? EX1_DR : SH_DR;
         SH_DR:  w_next = r_tms ? EX1_DR : SH_DR;
         EX1_DR: w_next = r_tms ? UPD_DR : PAU_DR;
         PAU_DR: w_next = r_tms ? EX2_DR : PAU_DR;
         EX2_DR: w_next = r_tms ? UPD_DR : SH_DR;
         UPD_DR: w_next = r_tms ? SEL_DR : RTI;
         SEL_IR: w_next = r_tms ? TLR    : CAP_IR;
         CAP_IR: w_next = r_tms ? EX1_IR : SH_IR;
         SH_IR:  w_next = r_tms ? EX1_IR : SH_IR;
         EX1_IR: w_next = r_tms ? UPD_IR : PAU_IR;
         PAU_IR: w_next = r_tms ? EX2_IR : PAU_IR;
         EX2_IR: w_next = r_tms ? UPD_IR : SH_IR;
         UPD_IR: w_next = r_tms ? SEL_DR : RTI;
         default: w_next = TLR;
      endcase
   end

   // action strobes: the state's action fires on the rising edge that leaves it
   always_comb begin
      w_cap_dr = 1'b0;
      w_sh_dr  = 1'b0;
      w_upd_dr = 1'b0;
      w_cap_ir = 1'b0;
      w_sh_ir  = 1'b0;
      w_upd_ir = 1'b0;
      w_in_tlr = (r_state == TLR);
      if (w_adv) begin
         w_cap_dr = (r_state == CAP_DR);
         w_sh_dr  = (r_state == SH_DR);
         w_upd_dr = (r_state == UPD_DR);
         w_cap_ir = (r_state == CAP_IR);
         w_sh_ir  = (r_state == SH_IR);
         w_upd_ir = (r_state == UPD_IR);
      end
   end

   // instruction register and its shift stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ir    <= IR_IDCODE;
         r_ir_sr <= 5'h00;
      end else if (!jtag_trst_n || w_in_tlr) begin
         r_ir    <= IR_IDCODE;
      end else begin
         if (w_cap_ir)     r_ir_sr <= 5'b00001;
         else if (w_sh_ir) r_ir_sr <= {r_tdi, r_ir_sr[4:1]};
         if (w_upd_ir)     r_ir    <= r_ir_sr;
      end
   end

   // DR selection and length from the current instruction
   always_comb begin
      w_dr_sel = SEL_BYP;
      w_dr_len = 1;
      unique case (r_ir)
         IR_IDCODE: begin w_dr_sel = SEL_IDC; w_dr_len = 32;       end
         IR_DTMCS:  begin w_dr_sel = SEL_DTM; w_dr_len = 32;       end
         IR_DMI:    begin w_dr_sel = SEL_DMI; w_dr_len = int'(DrW); end
         default:   begin w_dr_sel = SEL_BYP; w_dr_len = 1;        end
      endcase
   end

   assign w_dtmcs    = {14'b0, 2'b0, 1'b0, 3'd1, r_sticky, 6'(AbitsW), 4'd1};
   assign w_rsp_fire = dmi_rsp_valid & r_outstanding;
   // a completing response takes precedence over a simultaneous capture
   assign w_cap_data = w_rsp_fire ? dmi_rsp_data : r_rsp_data;
   assign w_cap_stat = w_rsp_fire ? r_sticky :
                       ((r_outstanding || r_sticky == 2'd3) ? 2'd3 : r_sticky);

   // parallel capture value of the selected DR
   always_comb begin
      w_dr_cap = '0;
      unique case (w_dr_sel)
         SEL_IDC: w_dr_cap = DrW'(IdcodeValue);
         SEL_DTM: w_dr_cap = DrW'(w_dtmcs);
         SEL_DMI: w_dr_cap = {r_req_addr, w_cap_data, w_cap_stat};
         default: w_dr_cap = '0;
      endcase
   end

   // shift right, inserting TDI at the MSB of the selected length
   assign w_dr_shr = {1'b0, r_dr[DrW-1:1]};
   always_comb begin
      w_dr_shift = '0;
      for (int i = 0; i < int'(DrW); i++) begin
         if (i == w_dr_len - 1)     w_dr_shift[i] = r_tdi;
         else if (i < w_dr_len - 1) w_dr_shift[i] = w_dr_shr[i];
      end
   end

   // shared data shift register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       r_dr <= '0;
      else if (w_cap_dr) r_dr <= w_dr_cap;
      else if (w_sh_dr)  r_dr <= w_dr_shift;
   end

   // TDO changes only on TCK falling edges
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_tdo <= 1'b0;
      else if (w_fall) begin
         if (r_state == SH_IR)      r_tdo <= r_ir_sr[0];
         else if (r_state == SH_DR) r_tdo <= r_dr[0];
         else                       r_tdo <= 1'b0;
      end
   end

   assign w_upd_dmi = w_upd_dr && (w_dr_sel == SEL_DMI);
   assign w_upd_dtm = w_upd_dr && (w_dr_sel == SEL_DTM);
   assign w_cap_dmi = w_cap_dr && (w_dr_sel == SEL_DMI);
   assign w_op      = r_dr[1:0];
   assign w_busy    = r_outstanding & ~w_rsp_fire;
   assign w_issue   = w_upd_dmi && !r_outstanding && (r_sticky == 2'd0) &&
                      (w_op == 2'd1 || w_op == 2'd2);

   // DMI request/response tracking; later statements take priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req_valid   <= 1'b0;
         r_outstanding <= 1'b0;
         r_req_addr    <= '0;
         r_req_data    <= '0;
         r_req_op      <= '0;
         r_rsp_data    <= '0;
         r_sticky      <= '0;
      end else begin
         if (r_req_valid && dmi_req_ready) r_req_valid <= 1'b0;
         if (w_rsp_fire) begin
            r_rsp_data    <= dmi_rsp_data;
            r_outstanding <= 1'b0;
            if (dmi_rsp_resp == 2'd2 && r_sticky == 2'd0) r_sticky <= 2'd2;
         end else if (w_cap_dmi && r_outstanding) begin
            r_sticky <= 2'd3;
         end
         if (w_upd_dmi && w_busy) r_sticky <= 2'd3;
         if (w_issue) begin
            r_req_addr    <= r_dr[DrW-1:34];
            r_req_data    <= r_dr[33:2];
            r_req_op      <= w_op;
            r_req_valid   <= 1'b1;
            r_outstanding <= 1'b1;
         end
         if (w_upd_dtm && (r_dr[16] || r_dr[17])) r_sticky <= 2'd0;
         if (w_upd_dtm && r_dr[17]) begin
            r_outstanding <= 1'b0;
            r_req_valid   <= 1'b0;
         end
      end
   end

   assign jtag_tdo      = r_tdo;
   assign dmi_req_valid = r_req_valid;
   assign dmi_req_addr  = r_req_addr;
   assign dmi_req_data  = r_req_data;
   assign dmi_req_op    = r_req_op;

endmodule
